// File: rtl/tl_rx_credit_tracker.sv
// tl_rx_credit_tracker: receive-side TLP beat sequencer with cumulative credit-consumed counters.
// Checks the header/data/done beat order for posted, non-posted and completion TLPs. A TLP that
// completes normally adds its credits. A TLP with a protocol error is dropped without credit.
// Optional macro TL_RX_ERR_CNT_EN enables the saturating error counter driven on err_cnt_o.
module tl_rx_credit_tracker #(
  parameter int unsigned PIPE_DATA_WIDTH  = 256,
  parameter int unsigned CREDIT_DEPTH     = 12,
  parameter int unsigned MAX_PAYLOAD_SIZE = 128
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PIPE_DATA_WIDTH-1:0] tlp_i,
  input  logic [2:0]                 req_i,
  output logic                       hdr_valid_o,
  output logic [127:0]               hdr_o,
  output logic [1:0]                 hdr_class_o,
  output logic                       data_valid_o,
  output logic [PIPE_DATA_WIDTH-1:0] data_o,
  output logic                       tlp_done_o,
  output logic [CREDIT_DEPTH-1:0]    cc_ph_o,
  output logic [CREDIT_DEPTH-1:0]    cc_pd_o,
  output logic [CREDIT_DEPTH-1:0]    cc_nh_o,
  output logic [CREDIT_DEPTH-1:0]    cc_ch_o,
  output logic [CREDIT_DEPTH-1:0]    cc_cd_o,
  output logic                       err_o,
  output logic [1:0]                 err_code_o,
  output logic [7:0]                 err_cnt_o
);

  localparam logic [2:0] ReqIdle    = 3'd0;
  localparam logic [2:0] ReqPHdr    = 3'd1;
  localparam logic [2:0] ReqPData   = 3'd2;
  localparam logic [2:0] ReqNpHdr   = 3'd3;
  localparam logic [2:0] ReqCplHdr  = 3'd5;
  localparam logic [2:0] ReqCplData = 3'd6;
  localparam logic [2:0] ReqDone    = 3'd7;

  localparam logic [1:0] ClsP   = 2'd0;
  localparam logic [1:0] ClsNp  = 2'd1;
  localparam logic [1:0] ClsCpl = 2'd2;

  localparam logic [1:0] ErrNone     = 2'd0;
  localparam logic [1:0] ErrSeq      = 2'd1;
  localparam logic [1:0] ErrClass    = 2'd2;
  localparam logic [1:0] ErrOversize = 2'd3;

  localparam logic [CREDIT_DEPTH-1:0] CcOne = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_WAIT_DONE,
    S_DROP
  } state_e;

  state_e                      state_q, state_d;
  logic                        hdr_valid_q, hdr_valid_d;
  logic [127:0]                hdr_q, hdr_d;
  logic [1:0]                  cls_q, cls_d;
  logic                        data_valid_q, data_valid_d;
  logic [PIPE_DATA_WIDTH-1:0]  data_q, data_d;
  logic                        tlp_done_q, tlp_done_d;
  logic                        err_q, err_d;
  logic [1:0]                  err_code_q, err_code_d;
  logic [7:0]                  beats_left_q, beats_left_d;
  logic [8:0]                  credits_q, credits_d;
  logic                        with_data_q, with_data_d;
  logic [CREDIT_DEPTH-1:0]     cc_ph_q, cc_ph_d;
  logic [CREDIT_DEPTH-1:0]     cc_pd_q, cc_pd_d;
  logic [CREDIT_DEPTH-1:0]     cc_nh_q, cc_nh_d;
  logic [CREDIT_DEPTH-1:0]     cc_ch_q, cc_ch_d;
  logic [CREDIT_DEPTH-1:0]     cc_cd_q, cc_cd_d;

  logic [9:0]  len_raw;
  logic [10:0] len_dw;
  logic [12:0] len_bytes;
  logic        has_data;
  logic        oversize;
  logic [7:0]  hdr_beats;
  logic [8:0]  hdr_credits;
  logic        req_is_hdr;
  logic        req_is_data;
  logic [1:0]  req_hdr_cls;
  logic [1:0]  req_data_cls;

  // Header field decode and beat-code classification for the current input beat.
  always_comb begin
    len_raw     = tlp_i[9:0];
    // A Length field of zero encodes 1024 DW.
    len_dw      = (len_raw == 10'd0) ? 11'd1024 : {1'b0, len_raw};
    len_bytes   = {len_dw, 2'b00};
    has_data    = tlp_i[30];
    oversize    = has_data && (32'(len_bytes) > MAX_PAYLOAD_SIZE);
    // 8 DW fit in one 256-bit beat; one data credit covers 4 DW.
    hdr_beats   = 8'((len_dw + 11'd7) >> 3);
    hdr_credits = 9'((len_dw + 11'd3) >> 2);

    req_is_hdr  = 1'b0;
    req_hdr_cls = ClsP;
    case (req_i)
      ReqPHdr:   begin req_is_hdr = 1'b1; req_hdr_cls = ClsP;   end
      ReqNpHdr:  begin req_is_hdr = 1'b1; req_hdr_cls = ClsNp;  end
      ReqCplHdr: begin req_is_hdr = 1'b1; req_hdr_cls = ClsCpl; end
      default:   ;
    endcase
    req_is_data  = (req_i == ReqPData) || (req_i == ReqCplData);
    req_data_cls = (req_i == ReqCplData) ? ClsCpl : ClsP;
  end

  // Sequencing FSM: steers each beat to the outputs, flags errors and commits credits.
  always_comb begin
    state_d      = state_q;
    hdr_valid_d  = 1'b0;
    hdr_d        = hdr_q;
    cls_d        = cls_q;
    data_valid_d = 1'b0;
    data_d       = data_q;
    tlp_done_d   = 1'b0;
    err_d        = 1'b0;
    err_code_d   = ErrNone;
    beats_left_d = beats_left_q;
    credits_d    = credits_q;
    with_data_d  = with_data_q;
    cc_ph_d      = cc_ph_q;
    cc_pd_d      = cc_pd_q;
    cc_nh_d      = cc_nh_q;
    cc_ch_d      = cc_ch_q;
    cc_cd_d      = cc_cd_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_is_hdr) begin
          if (oversize) begin
            err_d      = 1'b1;
            err_code_d = ErrOversize;
            state_d    = S_DROP;
          end else if ((req_hdr_cls == ClsNp) && has_data) begin
            err_d      = 1'b1;
            err_code_d = ErrClass;
            state_d    = S_DROP;
          end else begin
            hdr_valid_d  = 1'b1;
            hdr_d        = tlp_i[127:0];
            cls_d        = req_hdr_cls;
            beats_left_d = hdr_beats;
            credits_d    = hdr_credits;
            with_data_d  = has_data;
            state_d      = has_data ? S_DATA : S_WAIT_DONE;
          end
        end else if (req_i != ReqIdle) begin
          err_d      = 1'b1;
          err_code_d = ErrSeq;
        end
      end

      S_DATA: begin
        if (req_is_data) begin
          if (req_data_cls == cls_q) begin
            data_valid_d = 1'b1;
            data_d       = tlp_i;
            beats_left_d = beats_left_q - 8'd1;
            if (beats_left_q == 8'd1) begin
              state_d = S_WAIT_DONE;
            end
          end else begin
            err_d      = 1'b1;
            err_code_d = ErrClass;
            state_d    = S_DROP;
          end
        end else if (req_i != ReqIdle) begin
          err_d      = 1'b1;
          err_code_d = ErrSeq;
          state_d    = S_DROP;
        end
      end

      S_WAIT_DONE: begin
        if (req_i == ReqDone) begin
          tlp_done_d = 1'b1;
          state_d    = S_IDLE;
          case (cls_q)
            ClsP: begin
              cc_ph_d = cc_ph_q + CcOne;
              if (with_data_q) begin
                cc_pd_d = cc_pd_q + CREDIT_DEPTH'(credits_q);
              end
            end
            ClsNp: cc_nh_d = cc_nh_q + CcOne;
            ClsCpl: begin
              cc_ch_d = cc_ch_q + CcOne;
              if (with_data_q) begin
                cc_cd_d = cc_cd_q + CREDIT_DEPTH'(credits_q);
              end
            end
            default: ;
          endcase
        end else if (req_i != ReqIdle) begin
          err_d      = 1'b1;
          err_code_d = ErrSeq;
          state_d    = S_DROP;
        end
      end

      S_DROP: begin
        // Beats are discarded silently until the TLP boundary.
        if (req_i == ReqDone) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State, output and credit registers; reset clears everything asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      hdr_valid_q  <= 1'b0;
      hdr_q        <= '0;
      cls_q        <= ClsP;
      data_valid_q <= 1'b0;
      data_q       <= '0;
      tlp_done_q   <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= ErrNone;
      beats_left_q <= '0;
      credits_q    <= '0;
      with_data_q  <= 1'b0;
      cc_ph_q      <= '0;
      cc_pd_q      <= '0;
      cc_nh_q      <= '0;
      cc_ch_q      <= '0;
      cc_cd_q      <= '0;
    end else begin
      state_q      <= state_d;
      hdr_valid_q  <= hdr_valid_d;
      hdr_q        <= hdr_d;
      cls_q        <= cls_d;
      data_valid_q <= data_valid_d;
      data_q       <= data_d;
      tlp_done_q   <= tlp_done_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
      beats_left_q <= beats_left_d;
      credits_q    <= credits_d;
      with_data_q  <= with_data_d;
      cc_ph_q      <= cc_ph_d;
      cc_pd_q      <= cc_pd_d;
      cc_nh_q      <= cc_nh_d;
      cc_ch_q      <= cc_ch_d;
      cc_cd_q      <= cc_cd_d;
    end
  end

`ifdef TL_RX_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Saturating count of flagged protocol errors, updated with the err_o pulse.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // Error counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= 8'h00;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt_o = err_cnt_q;
`else
  assign err_cnt_o = 8'h00;
`endif

  assign hdr_valid_o  = hdr_valid_q;
  assign hdr_o        = hdr_q;
  assign hdr_class_o  = cls_q;
  assign data_valid_o = data_valid_q;
  assign data_o       = data_q;
  assign tlp_done_o   = tlp_done_q;
  assign cc_ph_o      = cc_ph_q;
  assign cc_pd_o      = cc_pd_q;
  assign cc_nh_o      = cc_nh_q;
  assign cc_ch_o      = cc_ch_q;
  assign cc_cd_o      = cc_cd_q;
  assign err_o        = err_q;
  assign err_code_o   = err_code_q;

endmodule
